sram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single 16-bit external SRAM. Port 0 serves the MEM stage's data accesses; port 1 serves a secondary master (program loader / debug). Each 32-bit request is granted and then run as two 16-bit SRAM phases (low halfword, then high halfword), and completion is signalled with a one-cycle ready pulse. It sits between the MEM stage and the SRAM pins; the MEM stage derives its pipeline freeze from `~p0_ready` while its request is outstanding.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_io.sv | 37 +++
 rtl/sram_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter.
// Build option SRAM_ARB_ROUND_ROBIN_EN is consumed by sram_arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } sram_arb_state_t;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;
   localparam int WCNT_W  = 4;

endpackage

// File: rtl/sram_io.sv
// sram_io: SRAM data-bus driver, write-halfword mux and read capture.
// Read halves land in the granted port's rdata and are held there.
module sram_io
   import sram_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               drive,
   input  logic               cap,
   input  logic               hi,
   input  logic               grant,
   input  logic [31:0]        wdata,
   inout  wire  [SRAM_DW-1:0] dq,
   output logic [31:0]        p0_rdata,
   output logic [31:0]        p1_rdata
);

   logic [SRAM_DW-1:0] wr_half;

   assign wr_half = hi ? wdata[31:16] : wdata[15:0];
   assign dq      = drive ? wr_half : 'z;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0_rdata <= '0;
         p1_rdata <= '0;
      end else if (cap) begin
         unique case ({grant, hi})
            2'b00: p0_rdata[15:0]  <= dq;
            2'b01: p0_rdata[31:16] <= dq;
            2'b10: p1_rdata[15:0]  <= dq;
            2'b11: p1_rdata[31:16] <= dq;
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter/sequencer for a 16-bit external SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin, else port 0 has priority.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               p0_req,
   input  logic               p0_we,
   input  logic [31:0]        p0_addr,
   input  logic [31:0]        p0_wdata,
   output logic [31:0]        p0_rdata,
   output logic               p0_ready,
   input  logic               p1_req,
   input  logic               p1_we,
   input  logic [31:0]        p1_addr,
   input  logic [31:0]        p1_wdata,
   output logic [31:0]        p1_rdata,
   output logic               p1_ready,
   output logic               busy,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);

   sram_arb_state_t   state;
   logic [WCNT_W-1:0] cnt;
   logic              grant;
   logic              we_q;
   logic [16:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              pick;
   logic              last;
   logic              active;
   logic              hi;
   logic              unused_addr;

   assign unused_addr = ^{p0_addr[31:19], p0_addr[1:0],
                          p1_addr[31:19], p1_addr[1:0]};

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic rr_ptr;

   // rr_ptr names the port that wins the next tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_ptr <= 1'b0;
      else if (state == DONE)
         rr_ptr <= ~grant;
   end

   assign pick = (p0_req & p1_req) ? rr_ptr : p1_req;
`else
   assign pick = ~p0_req;
`endif

   assign last   = (cnt == WCNT_W'(WAIT_CYCLES - 1));
   assign active = (state == LO) || (state == HI);
   assign hi     = (state == HI);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         grant   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (p0_req | p1_req) begin
                  grant   <= pick;
                  we_q    <= pick ? p1_we : p0_we;
                  addr_q  <= pick ? p1_addr[18:2] : p0_addr[18:2];
                  wdata_q <= pick ? p1_wdata : p0_wdata;
                  cnt     <= '0;
                  state   <= LO;
               end
            end
            LO: begin
               if (last) begin
                  cnt   <= '0;
                  state <= HI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HI: begin
               if (last)
                  state <= DONE;
               else
                  cnt <= cnt + 1'b1;
            end
            DONE: state <= IDLE;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign p0_ready = (state == DONE) & ~grant;
   assign p1_ready = (state == DONE) & grant;

   // WE_N released on the last cycle of a phase for address/data hold
   assign SRAM_CE_N = ~active;
   assign SRAM_UB_N = ~active;
   assign SRAM_LB_N = ~active;
   assign SRAM_OE_N = ~(active & ~we_q);
   assign SRAM_WE_N = ~(active & we_q & ~last);
   assign SRAM_ADDR = active ? {addr_q, hi} : '0;

   sram_io u_io (
      .clk      (clk),
      .rst      (rst),
      .drive    (active & we_q),
      .cap      (active & ~we_q & last),
      .hi       (hi),
      .grant    (grant),
      .wdata    (wdata_q),
      .dq       (SRAM_DQ),
      .p0_rdata (p0_rdata),
      .p1_rdata (p1_rdata)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random checks of sram_arbiter with an SRAM model.
// Expectations follow SRAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
   logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
   logic [31:0] p0_rdata, p1_rdata;
   logic        p0_ready, p1_ready, busy;
   wire  [15:0] dq;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

   logic        q_req = 0;
   logic [31:0] q_zero = 0;
   logic [31:0] q0_rdata, q1_rdata;
   logic        q0_ready, q1_ready, q_busy;
   wire  [15:0] dq4;
   logic [17:0] q_addr;
   logic        q_ub, q_lb, q_we, q_ce, q_oe;

   always #5 clk = ~clk;

   sram_arbiter #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ready(p0_ready),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ready(p1_ready),
      .busy(busy), .SRAM_DQ(dq), .SRAM_ADDR(SRAM_ADDR),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N),
      .SRAM_OE_N(SRAM_OE_N)
   );

   sram_arbiter #(.WAIT_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst),
      .p0_req(1'b0), .p0_we(1'b0), .p0_addr(q_zero),
      .p0_wdata(q_zero), .p0_rdata(q0_rdata), .p0_ready(q0_ready),
      .p1_req(q_req), .p1_we(1'b1), .p1_addr(32'h0000_0008),
      .p1_wdata(32'hCAFE_F00D), .p1_rdata(q1_rdata), .p1_ready(q1_ready),
      .busy(q_busy), .SRAM_DQ(dq4), .SRAM_ADDR(q_addr),
      .SRAM_UB_N(q_ub), .SRAM_LB_N(q_lb),
      .SRAM_WE_N(q_we), .SRAM_CE_N(q_ce), .SRAM_OE_N(q_oe)
   );

   // Halfword SRAM device model
   logic [15:0] mem [0:1023];
   always @(posedge clk)
      if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= dq;
   assign dq = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[9:0]] : 'z;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] ref_mem [int];
   logic [31:0] exp_rd [2];
   logic [17:0] obs_addr [0:40];
   logic [15:0] obs_dq   [0:40];
   logic        obs_wen  [0:40];
   logic        obs_busy [0:40];
   logic [31:0] got_rdata;
   logic        other_ready;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int port, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd);
      if (port == 0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
      end
   endtask

   // Runs one request from an IDLE cycle; lat = cycles until ready, -1 on timeout
   task automatic run_txn(input int port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int drop_at, output int lat);
      int  c;
      bit  got;
      logic mine, theirs;
      c = 0; got = 0; other_ready = 0;
      set_port(port, 1'b1, we, addr, wd);
      while (!got && c < 40) begin
         tick();
         c++;
         obs_addr[c] = SRAM_ADDR;
         obs_dq[c]   = dq;
         obs_wen[c]  = SRAM_WE_N;
         obs_busy[c] = busy;
         mine   = (port == 0) ? p0_ready : p1_ready;
         theirs = (port == 0) ? p1_ready : p0_ready;
         if (theirs) other_ready = 1;
         if (c == 1)
            set_port(port, 1'b1, ~we, $urandom, $urandom);
         if (c == drop_at)
            set_port(port, 1'b0, ~we, $urandom, $urandom);
         if (mine) begin
            got = 1;
            got_rdata = (port == 0) ? p0_rdata : p1_rdata;
         end
      end
      set_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
      lat = got ? c : -1;
      tick();
   endtask

   initial begin
      int          lat, n, c, ng, p1_seen, wn_lo, wn_hi;
      logic        w, last_served;
      logic [31:0] a, d;
      logic [31:0] written [$];

      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_ready", {p0_ready, p1_ready}, 0);
      chk("rst_rdata", p0_rdata | p1_rdata, 0);
      chk("rst_ctrl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N},
          5'h1f);
      chk("rst_addr", SRAM_ADDR, 0);
      rst = 1'b1;
      tick();

      run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, lat);
      ref_mem[32'h10] = 32'hDEADBEEF;
      chk("wr_lat", lat, 5);
      chk("wr_lo_addr", obs_addr[1], 18'h8);
      chk("wr_lo_dq", obs_dq[1], 16'hBEEF);
      chk("wr_lo_we0", obs_wen[1], 0);
      chk("wr_lo_we1", obs_wen[2], 1);
      chk("wr_hi_addr", obs_addr[3], 18'h9);
      chk("wr_hi_dq", obs_dq[3], 16'hDEAD);
      chk("wr_hi_we", {obs_wen[3], obs_wen[4]}, 2'b01);
      chk("wr_done_busy", obs_busy[5], 1);
      chk("wr_idle_busy", busy, 0);

      run_txn(0, 1'b0, 32'h10, 32'h0, 0, lat);
      chk("rd_lat", lat, 5);
      chk("rd_data", got_rdata, 32'hDEADBEEF);
      chk("rd_hold", p0_rdata, 32'hDEADBEEF);
      chk("rd_p1_clean", p1_rdata, 0);
      chk("rd_other", other_ready, 0);
      exp_rd[0] = 32'hDEADBEEF;
      exp_rd[1] = 32'h0;

      run_txn(0, 1'b0, 32'h10, 32'h0, 2, lat);
      chk("drop_lat", lat, 5);

      for (int i = 0; i < 16; i++) begin
         int p;
         p = $urandom_range(0, 1);
         if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
            a = 32'h200 + 4 * $urandom_range(0, 15);
            d = $urandom;
            run_txn(p, 1'b1, a, d, 0, lat);
            ref_mem[a] = d;
            written.push_back(a);
         end else begin
            a = written[$urandom_range(0, written.size() - 1)];
            run_txn(p, 1'b0, a, 32'h0, $urandom_range(0, 4), lat);
            exp_rd[p] = ref_mem[a];
            chk("rnd_rdata", got_rdata, ref_mem[a]);
         end
         chk("rnd_lat", lat, 5);
         chk("rnd_hold", {p0_rdata, p1_rdata}, {exp_rd[0], exp_rd[1]});
      end

      set_port(1, 1'b1, 1'b1, 32'h40, 32'h12345678);
      repeat (3) tick();
      chk("mid_hi_addr", SRAM_ADDR, 18'h21);
      rst = 1'b0;
      #1;
      chk("mid_rst_ctrl",
          {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1f);
      chk("mid_rst_addr", SRAM_ADDR, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rdata", p0_rdata | p1_rdata, 0);
      set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      c = 0;
      repeat (3) begin
         tick();
         if (p0_ready || p1_ready) c++;
      end
      chk("mid_rst_noready", c, 0);
      rst = 1'b1;
      tick();
      run_txn(1, 1'b1, 32'h44, 32'h5A5A_C3C3, 0, lat);
      ref_mem[32'h44] = 32'h5A5A_C3C3;
      chk("post_rst_lat", lat, 5);
      run_txn(1, 1'b0, 32'h44, 32'h0, 0, lat);
      chk("post_rst_rd", got_rdata, 32'h5A5A_C3C3);

      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      last_served = 1'b1;
      ng = RR ? 4 : 3;
      n = 0; c = 0; p1_seen = 0;
      set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
      set_port(1, 1'b1, 1'b0, 32'h44, 32'h0);
      while (n < ng && c < 100) begin
         tick();
         c++;
         if (p0_ready || p1_ready) begin
            w = p1_ready;
            if (w) p1_seen++;
            chk("both_ready", p0_ready & p1_ready, 0);
            chk("grant", w, RR ? ~last_served : 1'b0);
            chk("arb_rdata", w ? p1_rdata : p0_rdata,
                w ? ref_mem[32'h44] : ref_mem[32'h10]);
            last_served = w;
            n++;
            if (n == ng) begin
               p0_req = 1'b0;
               if (RR) p1_req = 1'b0;
            end
         end
      end
      chk("arb_count", n, ng);
      if (!RR) begin
         chk("starve_p1", p1_seen, 0);
         c = 0;
         while (!p1_ready && c < 20) begin
            tick();
            c++;
         end
         chk("p1_after_starve", p1_ready, 1);
         p1_req = 1'b0;
      end
      tick();

      q_req = 1'b1;
      c = 0; wn_lo = 0; wn_hi = 0;
      while (!q1_ready && c < 40) begin
         tick();
         c++;
         if (c == 1) q_req = 1'b0;
         if (!q_ce && !q_we && !q_addr[0]) wn_lo++;
         if (!q_ce && !q_we && q_addr[0]) wn_hi++;
      end
      chk("w4_lat", c, 9);
      chk("w4_we_lo", wn_lo, 3);
      chk("w4_we_hi", wn_hi, 3);
      chk("w4_p0_ready", q0_ready, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
